// File: rtl/arm_pkg.sv
// Shared types for the ARM-subset execute stage: opcodes, shift types,
// the NZCV flag layout, multiplier FSM states and a rotate helper.
package arm_pkg;

  localparam int W = 32;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MUL = 4'b1111
  } exe_cmd_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  function automatic logic [W-1:0] ror32(input logic [W-1:0] x, input logic [4:0] amt);
    logic [2*W-1:0] t;
    t = {x, x} >> amt;
    return t[W-1:0];
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX operand bundle into the execute stage and its results back out.
interface exe_stage_if;
  import arm_pkg::*;

  logic [3:0]   EXE_CMD;
  logic         MEM_R_EN;
  logic         MEM_W_EN;
  logic         S;
  logic         B;
  logic         IMM;
  logic [11:0]  ShiftOperand;
  logic [23:0]  Signed_IMM_24;
  logic [W-1:0] PC;
  logic [W-1:0] VAL_RN;
  logic [W-1:0] VAL_RM;
  logic [3:0]   SR_IN;
  logic [W-1:0] ALU_RES;
  logic [W-1:0] BR_ADDR;
  logic         BR_TAKEN;
  logic [3:0]   SR;
  logic         STALL;

  modport master (
    output EXE_CMD, MEM_R_EN, MEM_W_EN, S, B, IMM, ShiftOperand, Signed_IMM_24,
           PC, VAL_RN, VAL_RM, SR_IN,
    input  ALU_RES, BR_ADDR, BR_TAKEN, SR, STALL
  );

  modport slave (
    input  EXE_CMD, MEM_R_EN, MEM_W_EN, S, B, IMM, ShiftOperand, Signed_IMM_24,
           PC, VAL_RN, VAL_RM, SR_IN,
    output ALU_RES, BR_ADDR, BR_TAKEN, SR, STALL
  );

endinterface

// File: rtl/exe_stage_mul.sv
// Shift-add 32x32 multiplier: one partial product per cycle, 32 BUSY cycles,
// then a single DONE cycle presenting the low 32 bits of the product.
module exe_mul
  import arm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  mul_state_t   state_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] mcand_q;
  logic [W-1:0] mplr_q;
  logic [4:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= a;
            mplr_q  <= b;
            acc_q   <= '0;
            cnt_q   <= 5'd0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (mplr_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU with NZCV, branch target and the status
// register. Build with EXE_MUL_EN to add the multi-cycle MUL and its STALL.
module exe_stage
  import arm_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  exe_stage_if.slave bus
);

  logic [W-1:0] val2_s;
  logic [4:0]   shamt_s;
  shift_t       shtype_s;
  logic [W-1:0] add_b_s;
  logic         add_cin_s;
  logic         is_arith_s;
  logic [W:0]   sum_s;
  logic [W-1:0] res_s;
  nzcv_t        flags_s;
  nzcv_t        sr_q;
  logic         sr_we_s;
  logic         c_in_s;
  logic         sr_in_unused_s;

  assign c_in_s         = bus.SR_IN[1];
  assign sr_in_unused_s = ^{bus.SR_IN[3:2], bus.SR_IN[0]};
  assign shamt_s        = bus.ShiftOperand[11:7];
  assign shtype_s       = shift_t'(bus.ShiftOperand[6:5]);

  // Second operand: rotated immediate, memory offset, or shifted Rm
  always_comb begin
    val2_s = bus.VAL_RM;
    if (bus.IMM) begin
      val2_s = ror32({24'd0, bus.ShiftOperand[7:0]}, {bus.ShiftOperand[11:8], 1'b0});
    end else if (bus.MEM_R_EN || bus.MEM_W_EN) begin
      val2_s = {20'd0, bus.ShiftOperand};
    end else begin
      case (shtype_s)
        SH_LSL:  val2_s = bus.VAL_RM << shamt_s;
        SH_LSR:  val2_s = bus.VAL_RM >> shamt_s;
        SH_ASR:  val2_s = W'($signed(bus.VAL_RM) >>> shamt_s);
        SH_ROR:  val2_s = ror32(bus.VAL_RM, shamt_s);
        default: val2_s = bus.VAL_RM;
      endcase
    end
  end

  // Subtraction is Rn + ~Val2 + carry, so C comes out as NOT borrow
  always_comb begin
    add_b_s    = val2_s;
    add_cin_s  = 1'b0;
    is_arith_s = 1'b0;
    case (bus.EXE_CMD)
      CMD_ADD: is_arith_s = 1'b1;
      CMD_ADC: begin is_arith_s = 1'b1; add_cin_s = c_in_s; end
      CMD_SUB: begin is_arith_s = 1'b1; add_b_s = ~val2_s; add_cin_s = 1'b1; end
      CMD_SBC: begin is_arith_s = 1'b1; add_b_s = ~val2_s; add_cin_s = c_in_s; end
      default: is_arith_s = 1'b0;
    endcase
  end

  assign sum_s = {1'b0, bus.VAL_RN} + {1'b0, add_b_s} + {{W{1'b0}}, add_cin_s};

`ifdef EXE_MUL_EN
  logic         mul_start_s;
  logic         mul_busy_s;
  logic         mul_done_s;
  logic [W-1:0] mul_prod_s;

  assign mul_start_s = (bus.EXE_CMD == CMD_MUL);

  exe_mul u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .a       (bus.VAL_RN),
    .b       (bus.VAL_RM),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // DONE still sees the MUL opcode, so it must not re-stall
  assign bus.STALL = mul_busy_s | (mul_start_s & ~mul_done_s);
`else
  assign bus.STALL = 1'b0;
`endif

  // ALU result selection
  always_comb begin
    res_s = '0;
    case (bus.EXE_CMD)
      CMD_MOV: res_s = val2_s;
      CMD_MVN: res_s = ~val2_s;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: res_s = sum_s[W-1:0];
      CMD_AND: res_s = bus.VAL_RN & val2_s;
      CMD_ORR: res_s = bus.VAL_RN | val2_s;
      CMD_EOR: res_s = bus.VAL_RN ^ val2_s;
`ifdef EXE_MUL_EN
      CMD_MUL: res_s = mul_done_s ? mul_prod_s : '0;
`else
      CMD_MUL: res_s = '0;
`endif
      default: res_s = '0;
    endcase
  end

  always_comb begin
    flags_s.n = res_s[W-1];
    flags_s.z = (res_s == '0);
    flags_s.c = is_arith_s ? sum_s[W] : sr_q.c;
    flags_s.v = is_arith_s ? ((bus.VAL_RN[W-1] == add_b_s[W-1]) && (res_s[W-1] != bus.VAL_RN[W-1]))
                           : sr_q.v;
  end

`ifdef EXE_MUL_EN
  assign sr_we_s = bus.S && ((bus.EXE_CMD != CMD_MUL) || mul_done_s);
`else
  assign sr_we_s = bus.S && (bus.EXE_CMD != CMD_MUL);
`endif

  // Architectural status register
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (sr_we_s) begin
      sr_q <= flags_s;
    end
  end

  assign bus.ALU_RES  = res_s;
  assign bus.BR_ADDR  = bus.PC + {{6{bus.Signed_IMM_24[23]}}, bus.Signed_IMM_24, 2'b00};
  assign bus.BR_TAKEN = bus.B;
  assign bus.SR       = sr_q;

endmodule
